// File: rtl/rpm_speed_filter.sv
// rpm_speed_filter: moving-average RPM filter with multi-cycle RPM-to-mph conversion
// Ports: clk50M/reset (async, active-high) | rpm_in: RPM sample source
//        rpm_avg, speed_mph: held results | speed_valid: one-cycle update strobe | busy: conversion running
module rpm_speed_filter #(
  parameter int SAMPLE_PERIOD = 50_000_000,
  parameter int DEPTH = 8,
  parameter int SPEED_NUM = 4680,
  parameter int SPEED_DEN = 63360
) (
  input  logic        clk50M,
  input  logic        reset,
  input  logic [15:0] rpm_in,
  output logic [15:0] rpm_avg,
  output logic [15:0] speed_mph,
  output logic        speed_valid,
  output logic        busy
);
  localparam int L = $clog2(DEPTH);
  localparam int SW = 16 + L;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [16:0] DEN = 17'(SPEED_DEN);
  typedef enum logic [2:0] {IDLE, AVG, MUL, DIV, DONE} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [15:0] r_buf [DEPTH];
  logic [L-1:0] r_wp;
  logic [SW-1:0] r_sum;
  logic [15:0] r_avg_next, r_rpm_avg, r_speed, r_rem, w_rem;
  logic [31:0] r_quo, w_quo;
  logic [4:0] r_cnt;
  logic [16:0] w_trial;
  logic w_tick, w_ge;
  assign w_tick = r_timer == TMAX;
  // Restoring-division step: r_quo holds the remaining dividend bits shifted left while
  // quotient bits fill in from the bottom, so after 32 steps it holds the quotient.
  assign w_trial = {r_rem, r_quo[31]};
  assign w_ge = w_trial >= DEN;
  assign w_rem = w_ge ? 16'(w_trial - DEN) : w_trial[15:0];
  assign w_quo = {r_quo[30:0], w_ge};
  assign rpm_avg = r_rpm_avg;
  assign speed_mph = r_speed;
  assign speed_valid = r_state == DONE;
  assign busy = r_state != IDLE;
  always_ff @(posedge clk50M or posedge reset)
    if (reset) r_timer <= '0;
    else r_timer <= w_tick ? '0 : r_timer + TW'(1);
  always_ff @(posedge clk50M or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: w_next = w_tick ? AVG : IDLE;
      AVG: w_next = MUL;
      MUL: w_next = DIV;
      DIV: w_next = r_cnt == 5'd31 ? DONE : DIV;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk50M or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wp <= '0;
      r_sum <= '0;
      r_avg_next <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_rpm_avg <= '0;
      r_speed <= '0;
    end else begin
      // Ticks outside IDLE are dropped so the sum always matches the buffer contents.
      if (r_state == IDLE && w_tick) begin
        r_sum <= r_sum + SW'(rpm_in) - SW'(r_buf[r_wp]);
        r_buf[r_wp] <= rpm_in;
        r_wp <= r_wp + L'(1);
      end
      if (r_state == AVG) r_avg_next <= r_sum[SW-1:L];
      if (r_state == MUL) begin
        r_quo <= 32'(r_avg_next) * 32'(SPEED_NUM);
        r_rem <= '0;
        r_cnt <= '0;
      end
      if (r_state == DIV) begin
        r_quo <= w_quo;
        r_rem <= w_rem;
        r_cnt <= r_cnt + 5'd1;
        // Results are loaded from the final step so they change on the edge that raises speed_valid.
        if (r_cnt == 5'd31) begin
          r_rpm_avg <= r_avg_next;
          r_speed <= |w_quo[31:16] ? 16'hFFFF : w_quo[15:0];
        end
      end
    end
  always_ff @(posedge clk50M)
    if (!reset && w_tick) tick_in_idle: assert (r_state == IDLE);
endmodule

// File: tb/tb_rpm_speed_filter.sv
// tb_rpm_speed_filter: scoreboard bench for rpm_speed_filter against a windowed-average reference
module tb_rpm_speed_filter;
  localparam int P = 100, D = 8, NUM = 4680, DEN = 63360;
  logic clk50M = 0, reset = 1;
  logic [15:0] rpm_in = 0;
  logic [15:0] rpm_avg, speed_mph;
  logic speed_valid, busy;
  typedef struct {int n; int avg; int spd;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int hist[$];
  int n = 0, vec = 0, bad = 0, last_avg = 0, last_spd = 0;
  longint ms, ma, mq;
  always #10 clk50M = ~clk50M;
  rpm_speed_filter #(.SAMPLE_PERIOD(P), .DEPTH(D), .SPEED_NUM(NUM), .SPEED_DEN(DEN)) dut (
    .clk50M(clk50M), .reset(reset), .rpm_in(rpm_in), .rpm_avg(rpm_avg),
    .speed_mph(speed_mph), .speed_valid(speed_valid), .busy(busy));
  task automatic chk(string nm, int act, int req);
    vec++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, n);
    end
  endtask
  // Reference: every P-th clock after reset release captures rpm_in; the result is the mean of
  // the last D captures (missing ones count as zero) and is due 34 clocks later.
  always @(posedge clk50M) begin
    if (reset) begin
      n = 0;
      hist.delete();
      exp_q.delete();
    end else begin
      n++;
      if (n % P == 0) begin
        hist.push_front(int'(rpm_in));
        if (hist.size() > D) void'(hist.pop_back());
        ms = 0;
        foreach (hist[i]) ms += hist[i];
        ma = ms / D;
        mq = ma * NUM / DEN;
        if (mq > 65535) mq = 65535;
        exp_q.push_back('{n + 34, int'(ma), int'(mq)});
      end
    end
  end
  always @(negedge clk50M) begin
    if (reset) begin
      chk("reset rpm_avg", int'(rpm_avg), 0);
      chk("reset speed_mph", int'(speed_mph), 0);
      chk("reset speed_valid", int'(speed_valid), 0);
      chk("reset busy", int'(busy), 0);
      last_avg = 0;
      last_spd = 0;
    end else begin
      if (speed_valid) begin
        if (exp_q.size() == 0) chk("unexpected speed_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("valid timing", n, e.n);
          chk("rpm_avg", int'(rpm_avg), e.avg);
          chk("speed_mph", int'(speed_mph), e.spd);
          last_avg = e.avg;
          last_spd = e.spd;
        end
      end else if (exp_q.size() > 0 && exp_q[0].n < n) begin
        chk("missing speed_valid", n, exp_q[0].n);
        void'(exp_q.pop_front());
      end
      chk("busy", int'(busy), int'(n >= P && n % P <= 34));
      chk("hold rpm_avg", int'(rpm_avg), last_avg);
      chk("hold speed_mph", int'(speed_mph), last_spd);
    end
  end
  task automatic cyc(int k, int v, bit rnd);
    repeat (k) begin
      @(negedge clk50M);
      rpm_in = rnd ? 16'($urandom) : 16'(v);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk50M);
    #2 reset = 0;
    repeat (10) cyc(P, 1000, 0);
    repeat (10) cyc(P, 0, 0);
    repeat (10) cyc(P, 65535, 0);
    repeat (9) cyc(P, 0, 0);
    for (int i = 0; i < 12; i++) cyc(P, (i % 2) ? 1600 : 800, 0);
    cyc(20, 500, 0);
    #2 reset = 1;
    #1;
    chk("abort rpm_avg", int'(rpm_avg), 0);
    chk("abort speed_mph", int'(speed_mph), 0);
    chk("abort speed_valid", int'(speed_valid), 0);
    chk("abort busy", int'(busy), 0);
    repeat (3) @(negedge clk50M);
    #2 reset = 0;
    repeat (3) cyc(P, 2000, 0);
    repeat (10) cyc(P, 0, 1);
    cyc(40, 0, 0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
